inst_mem_arbiter: RTL

- Owns the single port of the instruction RAM and shares it between two requesters: the fetch read path and an Ethernet-fed program loader that writes new programs.
- Fetch normally owns the port. A load request makes the block stop fetch, drain in-flight reads, stream the writes, flush, and then pulse a restart so fetch resumes from address 0.
- Sits between instruction_bank's fetch logic and the RAM instance; its fetch_stall output drives fetchStall.

---
 rtl/inst_mem_arbiter.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/inst_mem_arbiter.sv
// inst_mem_arbiter: shares the instruction RAM port between fetch reads and the program loader.
// Optional INST_ARB_CHECKSUM_EN adds load_csum, a running XOR of in-range words written.
`default_nettype none

module inst_mem_arbiter #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024,
    parameter int RD_LAT = 2,            // 1 or 2
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_grant,
    output logic              fetch_rvalid,
    output logic [DATA_W-1:0] fetch_rdata,
    output logic              fetch_stall,
    output logic              restart,
    input  logic              load_valid,
    input  logic [ADDR_W:0]   load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic              load_err,
`ifdef INST_ARB_CHECKSUM_EN
    output logic [DATA_W-1:0] load_csum,
`endif
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_dout
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_DRAIN = 2'd1,
        S_LOAD  = 2'd2,
        S_FLUSH = 2'd3
    } state_t;

    // The S_FETCH cycle that sees load_valid already issues no grant, so it is
    // the first of the RD_LAT drain cycles; S_DRAIN covers the rest (at least one).
    localparam int DRAIN_LEN = (RD_LAT > 1) ? RD_LAT - 1 : 1;

    state_t            state, state_nxt;
    logic [1:0]        cnt, cnt_nxt;
    logic [RD_LAT-1:0] rv_sr;
    logic              err;
    logic              accept;
    logic              in_range;

    assign in_range     = load_addr < (ADDR_W+1)'(DEPTH);
    assign fetch_rvalid = rv_sr[RD_LAT-1];
    assign fetch_rdata  = ram_dout;
    assign ram_din      = load_data;
    assign load_err     = err;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_FETCH;
            cnt   <= 2'd0;
            rv_sr <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            rv_sr <= (rv_sr << 1) | RD_LAT'(fetch_grant);
            if (accept && !in_range) begin
                err <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        fetch_grant = 1'b0;
        fetch_stall = 1'b1;
        load_ready  = 1'b0;
        restart     = 1'b0;
        ram_addr    = fetch_addr;
        ram_we      = 1'b0;
        accept      = 1'b0;
        case (state)
            S_FETCH: begin
                fetch_stall = 1'b0;
                cnt_nxt     = 2'd0;
                if (load_valid) begin
                    state_nxt = S_DRAIN;
                end else begin
                    fetch_grant = fetch_req;
                end
            end
            S_DRAIN: begin
                if (cnt == 2'(DRAIN_LEN - 1)) begin
                    state_nxt = S_LOAD;
                    cnt_nxt   = 2'd0;
                end else begin
                    cnt_nxt = cnt + 2'd1;
                end
            end
            S_LOAD: begin
                load_ready = 1'b1;
                ram_addr   = load_addr[ADDR_W-1:0];
                ram_we     = load_valid && in_range;
                accept     = load_valid;
                cnt_nxt    = 2'd0;
                if (load_valid && load_last) begin
                    state_nxt = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (cnt == 2'(RD_LAT - 1)) begin
                    restart   = 1'b1;
                    state_nxt = S_FETCH;
                    cnt_nxt   = 2'd0;
                end else begin
                    cnt_nxt = cnt + 2'd1;
                end
            end
            default: begin
                state_nxt = S_FETCH;
            end
        endcase
    end

`ifdef INST_ARB_CHECKSUM_EN
    logic [DATA_W-1:0] csum;

    assign load_csum = csum;

    always_ff @(posedge clk) begin
        if (rst || (state == S_FETCH && load_valid)) begin
            csum <= '0;
        end else if (ram_we) begin
            csum <= csum ^ load_data;
        end
    end
`endif

endmodule

`default_nettype wire
